// File: rtl/encrypt_and_send.sv
// encrypt_and_send: serialises {addr,data} MSB first, XOR-encrypted per bit.
// Optional KEY_LFSR_EN: key stream comes from an internal 8-bit LFSR instead of key.
module encrypt_and_send #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              valid_in,
    output logic              ready,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              key,
    output logic              key_out,
    output logic              data_enc,
    output logic              clk_div,
    output logic              done
);

    localparam int F  = ADDR_W + DATA_W;
    localparam int CW = (F > 1) ? $clog2(F) : 1;
    localparam logic [CW-1:0] LAST = CW'(F - 1);
    localparam logic [CW-1:0] HALF = CW'(F / 2);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [F-1:0]  r_shift;
    logic [F-1:0]  w_shift_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_gap;
    logic [3:0]    w_gap_nxt;
    logic          r_tx;
    logic          w_tx_nxt;
    logic          r_clk_div;
    logic          w_last;
    logic          w_accept;

    assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);
    assign ready    = ena && ((r_state == S_IDLE) || (w_last && (GAP_CYCLES == 0)));
    assign w_accept = valid_in && ready;
    assign done     = w_last;
    assign clk_div  = r_clk_div;
    assign data_enc = r_tx ^ key_out;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_tx_nxt    = r_tx;
        if (w_accept) begin
            w_state_nxt = S_SHIFT;
            w_shift_nxt = {addr_in, data_in};
            w_cnt_nxt   = '0;
            w_tx_nxt    = addr_in[ADDR_W-1];
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (w_last) begin
                        w_tx_nxt  = 1'b0;
                        w_cnt_nxt = '0;
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_tx_nxt    = r_shift[F-2];
                        w_shift_nxt = r_shift << 1;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    w_tx_nxt = 1'b0;
                    if (r_gap == GAP_LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                default: begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Frame clock is registered from next state so its rising edge lands on bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_tx      <= 1'b0;
            r_clk_div <= 1'b0;
        end else if (ena) begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap     <= w_gap_nxt;
            r_tx      <= w_tx_nxt;
            r_clk_div <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt < HALF);
        end
    end

`ifdef KEY_LFSR_EN
    logic [7:0] r_lfsr;
    logic       w_fb;
    logic       w_unused_key;

    assign w_unused_key = key;
    assign w_fb         = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[4];
    assign key_out      = r_lfsr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'hA5;
        end else if (ena && (r_state == S_SHIFT)) begin
            r_lfsr <= {w_fb, r_lfsr[7:1]};
        end
    end
`else
    assign key_out = key;
`endif

endmodule

// File: tb/tb_encrypt_and_send.sv
// tb_encrypt_and_send: directed and random frames checked against a slot-queue model.
// Each accepted word expands into eight bit slots consumed one per enabled cycle.
module tb_encrypt_and_send;

    typedef struct packed {
        logic [7:0] w;
        logic [2:0] k;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic       valid_in = 1'b0;
    logic [3:0] addr_in = 4'h0;
    logic [3:0] data_in = 4'h0;
    logic       key = 1'b0;
    logic       ready;
    logic       key_out;
    logic       data_enc;
    logic       clk_div;
    logic       done;

    int    vectors = 0;
    int    miscompares = 0;
    slot_t q[$];
    slot_t cur;
    logic  cur_v = 1'b0;
    logic  fresh = 1'b0;
    logic  last_acc = 1'b0;
    logic [7:0] rx = 8'h00;

    always #5 clk = ~clk;

    encrypt_and_send #(
        .ADDR_W(4),
        .DATA_W(4),
        .GAP_CYCLES(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .valid_in(valid_in),
        .ready(ready),
        .addr_in(addr_in),
        .data_in(data_in),
        .key(key),
        .key_out(key_out),
        .data_enc(data_enc),
        .clk_div(clk_div),
        .done(done)
    );

    function automatic logic exp_ready();
        return ena && (!cur_v || cur.k == 3'd7);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_out();
        logic eb;
        logic ecd;
        logic edn;
        eb  = 1'b0;
        ecd = 1'b0;
        edn = 1'b0;
        if (cur_v) begin
            eb  = cur.w[7 - int'(cur.k)];
            ecd = (cur.k < 3'd4);
            edn = (cur.k == 3'd7);
        end
        chk("ready", 8'(ready), 8'(exp_ready()));
        chk("data_enc", 8'(data_enc), 8'(eb ^ key));
        chk("clk_div", 8'(clk_div), 8'(ecd));
        chk("done", 8'(done), 8'(edn));
        chk("key_out", 8'(key_out), 8'(key));
        if (fresh && cur_v) begin
            rx = {rx[6:0], data_enc ^ key_out};
            if (edn) chk("rx_word", rx, cur.w);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] w, input logic k,
                        input logic e, input logic r);
        logic acc;
        valid_in = v;
        {addr_in, data_in} = w;
        key = k;
        ena = e;
        rst_n = r;
        if (!r) begin
            q.delete();
            cur_v = 1'b0;
            fresh = 1'b0;
        end
        #1;
        check_out();
        acc = v && exp_ready();
        @(posedge clk);
        fresh = 1'b0;
        if (!r) begin
            q.delete();
            cur_v = 1'b0;
        end else if (e) begin
            if (acc) begin
                for (int i = 0; i < 8; i++) q.push_back('{w: w, k: 3'(i)});
            end
            if (q.size() > 0) begin
                cur   = q.pop_front();
                cur_v = 1'b1;
                fresh = 1'b1;
            end else begin
                cur_v = 1'b0;
            end
        end
        last_acc = acc && r;
        #1;
    endtask

    task automatic idle(input int n, input logic k);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, k, 1'b1, 1'b1);
    endtask

    task automatic offer(input logic [7:0] w, input logic k, input int maxc);
        int n;
        n = 0;
        do begin
            step(1'b1, w, k, 1'b1, 1'b1);
            n++;
        end while (!last_acc && n < maxc);
        vectors++;
        assert (last_acc) else begin
            miscompares++;
            $error("FAIL offer_timeout: word %h not accepted in %0d cycles", w, maxc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        key = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);

        offer(8'hA5, 1'b0, 1);
        idle(9, 1'b0);
        offer(8'hA5, 1'b1, 1);
        idle(9, 1'b1);

        offer(8'h3C, 1'b0, 1);
        offer(8'hF0, 1'b0, 10);
        idle(9, 1'b0);

        offer(8'h96, 1'b1, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
        idle(9, 1'b1);

        offer(8'h5A, 1'b0, 1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        offer(8'hC3, 1'b1, 1);
        idle(9, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) != 0));
        end
        idle(10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
